noc_credit_rx_buffer: RTL
=========================

// Module: noc_credit_rx_buffer
// PURPOSE
//  Receive end of the NoC credit-based flit link, the peer of the serializer shim's send_out/credit_in port.
//  Buffers incoming flits in a FIFO and exposes them as a valid/ready flit stream to the router or deserializer logic.
//  Returns one credit per flit drained. Tags packet heads, flags protocol overflow and counts delivered packets.
// PARAMETERS
//  FLIT_WIDTH         128  flit payload width (TDATA_WIDTH / SERIALIZATION_FACTOR)
//  TDEST_WIDTH        3    destination field width
//  FLIT_BUFFER_DEPTH  4    FIFO entries; power of 2, >= 2; equals the sender's initial credit count
//  PKT_CNT_WIDTH      16   width of the delivered-packet counter
// PORTS
//  clk           in   1                 single clock; all logic on rising edge
//  rst_n         in   1                 reset, asynchronous assert, active-low
//  data_in       in   FLIT_WIDTH        link flit payload
//  dest_in       in   TDEST_WIDTH       link flit destination
//  is_tail_in    in   1                 link flit is last of its packet
//  send_in       in   1                 link flit valid (one flit per cycle, no backpressure)
//  credit_out    out  1                 one-cycle pulse = one buffer slot freed
//  flit_valid    out  1                 FIFO head valid
//  flit_ready    in   1                 downstream accepts head
//  flit_data     out  FLIT_WIDTH        head payload
//  flit_dest     out  TDEST_WIDTH       head destination
//  flit_is_tail  out  1                 head is tail flit
//  flit_is_head  out  1                 head is first flit of a packet (single-flit packet: head=tail=1)
//  overflow_err  out  1                 sticky: flit arrived with no free slot
//  pkt_count     out  PKT_CNT_WIDTH     tail flits delivered downstream, modulo 2^PKT_CNT_WIDTH
// BEHAVIOUR
//  Reset: FIFO empty (count=0, pointers 0), mid_pkt=0, credit_out=0, overflow_err=0, pkt_count=0, flit_valid=0.
//   Reset mid-operation discards buffered flits and in-flight credits; the sender's credit counter is reset together.
//  Dequeue event: deq = flit_valid & flit_ready.
//  Enqueue event: send_in=1.
//   Accepted if count < DEPTH, or if count == DEPTH and deq=1 in the same cycle.
//   Otherwise the flit is dropped, FIFO is unchanged, and overflow_err sets on the next edge and stays set until reset.
//  Each entry stores {data, dest, tail, head}. Stored head = ~mid_pkt at enqueue.
//   mid_pkt is set on an accepted non-tail flit and cleared on an accepted tail flit.
//   A dropped flit does not change mid_pkt.
//  Output is first-word-fall-through, driven from the storage array at rd_ptr; flit_valid = (count != 0).
//  Latency: a flit enqueued at edge N is visible with flit_valid=1 after edge N (1 cycle). No combinational path from send_in.
//  Outputs are stable while flit_valid & ~flit_ready.
//  Count update: +1 on accepted enqueue without deq; -1 on deq without enqueue; unchanged when both occur.
//   rd_ptr and wr_ptr wrap modulo DEPTH.
//  credit_out: registered; equals deq of the previous cycle (one pulse per dequeued flit, 1-cycle delay). Never asserted for dropped flits.
//  pkt_count: +1 on each edge where deq & flit_is_tail; wraps to 0 from all-ones.
//  flit_data, flit_dest and flit_is_tail are don't-care when flit_valid=0. flit_is_head is forced to 0 when flit_valid=0.
// TESTING
//  1) Reset, then send_in=1 for one cycle with data=0x1, tail=1, flit_ready=1.
//     -> flit_valid 1 cycle later with data=0x1, head=1, tail=1; credit_out pulses 1 cycle after the dequeue; pkt_count=1.
//  2) 4-flit packet (data 0x10..0x13, tail on the last flit), flit_ready=0.
//     -> count reaches 4; head=1 only on 0x10.
//     -> Then flit_ready=1: 4 flits drain in order, exactly 4 credit_out pulses, pkt_count=1.
//  3) Fill FIFO (4 flits), flit_ready=0, send a 5th flit (0xFF).
//     -> overflow_err=1 from the next cycle onward; 0xFF never appears at the output; no extra credit pulse.
//  4) FIFO full with flit_ready=1 and send_in=1 in the same cycle.
//     -> flit accepted, count stays 4, overflow_err stays 0; continuous 1 flit/cycle streaming for 20 cycles with no loss.
//  5) Assert rst_n=0 mid-packet with 2 flits buffered.
//     -> flit_valid=0, credit_out=0, pkt_count=0 immediately; the next flit after release is tagged head=1.
//  6) Run 2^PKT_CNT_WIDTH+1 single-flit packets. -> pkt_count wraps to 1.

Source files
------------

// File: rtl/noc_credit_rx_buffer_if.sv
// noc_credit_rx_buffer_if: credit link from the sender plus the valid/ready flit stream to downstream
interface noc_credit_rx_buffer_if #(
    parameter int FLIT_WIDTH  = 128,
    parameter int TDEST_WIDTH = 3
);
    logic [FLIT_WIDTH-1:0]  data_in;
    logic [TDEST_WIDTH-1:0] dest_in;
    logic                   is_tail_in;
    logic                   send_in;
    logic                   credit_out;
    logic                   flit_valid;
    logic                   flit_ready;
    logic [FLIT_WIDTH-1:0]  flit_data;
    logic [TDEST_WIDTH-1:0] flit_dest;
    logic                   flit_is_tail;
    logic                   flit_is_head;
    modport master (
        output data_in, dest_in, is_tail_in, send_in, flit_ready,
        input  credit_out, flit_valid, flit_data, flit_dest, flit_is_tail, flit_is_head
    );
    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, flit_ready,
        output credit_out, flit_valid, flit_data, flit_dest, flit_is_tail, flit_is_head
    );
endinterface

// File: rtl/noc_credit_rx_buffer.sv
// noc_credit_rx_buffer: credit-returning FWFT flit FIFO with head tagging, overflow flag and packet counter
module noc_credit_rx_buffer #(
    parameter int FLIT_WIDTH        = 128,
    parameter int TDEST_WIDTH       = 3,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int PKT_CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    noc_credit_rx_buffer_if.slave    link,
    output logic                     overflow_err,
    output logic [PKT_CNT_WIDTH-1:0] pkt_count
);
    localparam int AW = $clog2(FLIT_BUFFER_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FLIT_BUFFER_DEPTH);
    typedef struct packed {
        logic [FLIT_WIDTH-1:0]  data;
        logic [TDEST_WIDTH-1:0] dest;
        logic                   tail;
        logic                   head;
    } entry_t;
    entry_t mem_q [FLIT_BUFFER_DEPTH];
    entry_t mem_d [FLIT_BUFFER_DEPTH];
    entry_t head_e;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0] count_q, count_d;
    logic mid_pkt_q, mid_pkt_d, credit_q, credit_d, ovf_q, ovf_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_q, pkt_d;
    logic deq, push;
    // A full FIFO still accepts when the head leaves in the same cycle
    always_comb begin
        head_e    = mem_q[rd_ptr_q];
        deq       = (count_q != '0) & link.flit_ready;
        push      = link.send_in & ((count_q != FULL) | deq);
        mem_d     = mem_q;
        mem_d[wr_ptr_q] = push ? entry_t'{data: link.data_in, dest: link.dest_in,
                                          tail: link.is_tail_in, head: ~mid_pkt_q}
                               : mem_q[wr_ptr_q];
        rd_ptr_d  = rd_ptr_q + AW'(deq);
        wr_ptr_d  = wr_ptr_q + AW'(push);
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(deq);
        mid_pkt_d = push ? ~link.is_tail_in : mid_pkt_q;
        credit_d  = deq;
        ovf_d     = ovf_q | (link.send_in & ~push);
        pkt_d     = pkt_q + PKT_CNT_WIDTH'(deq & head_e.tail);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            mid_pkt_q <= 1'b0;
            credit_q  <= 1'b0;
            ovf_q     <= 1'b0;
            pkt_q     <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            mid_pkt_q <= mid_pkt_d;
            credit_q  <= credit_d;
            ovf_q     <= ovf_d;
            pkt_q     <= pkt_d;
        end
    end
    // Storage needs no reset: entries are only observed while count is non-zero
    always_ff @(posedge clk) mem_q <= mem_d;
    assign link.credit_out   = credit_q;
    assign link.flit_valid   = count_q != '0;
    assign link.flit_data    = head_e.data;
    assign link.flit_dest    = head_e.dest;
    assign link.flit_is_tail = head_e.tail;
    assign link.flit_is_head = (count_q != '0) & head_e.head;
    assign overflow_err      = ovf_q;
    assign pkt_count         = pkt_q;
endmodule
